regfile_writeback_arbiter: RTL

- Producer side of the register bank's single write port. Merges single-cycle ALU results with multi-cycle (MCycle) results into one registered WE3/A3/WD3 stream.
- Buffers MCycle results that collide with ALU writes.
- Keeps a pending-write scoreboard that decode queries for RAW hazards.
- Sits between the execute stage / MCycle unit and the register bank.

---
 rtl/regfile_writeback_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_writeback_arbiter.sv
// Write-port arbiter for the register bank: merges ALU and MCycle results into one
// registered WE3/A3/WD3 stream, buffers colliding MCycle results, tracks pending MCycle writes.
module regfile_writeback_arbiter #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ALU_WE,
   input  logic [3:0]       ALU_A3,
   input  logic [31:0]      ALU_WD,
   input  logic             MC_VALID,
   input  logic [3:0]       MC_A3,
   input  logic [31:0]      MC_WD,
   output logic             MC_READY,
   input  logic             ISSUE_VALID,
   input  logic [3:0]       ISSUE_REG,
   input  logic [3:0]       Q_A1,
   input  logic [3:0]       Q_A2,
   output logic             PEND1,
   output logic             PEND2,
   output logic             WE3,
   output logic [3:0]       A3,
   output logic [31:0]      WD3,
   output logic [CNT_W-1:0] FIFO_COUNT,
   output logic             ERR_R15
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]       mem_a3_q [DEPTH];
   logic [31:0]      mem_wd_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [14:0]      pending_q, pending_d;
   logic             we3_q, we3_d;
   logic [3:0]       a3_q, a3_d;
   logic [31:0]      wd3_q, wd3_d;
   logic             err_q, err_d;

   logic        mc_acc, mc_ok, alu_ok, fifo_ne, push, pop;
   logic [15:0] pend_ext;

   assign MC_READY = !RESET && (count_q < CNT_W'(DEPTH));
   assign mc_acc   = MC_VALID && MC_READY;
   assign mc_ok    = mc_acc && (MC_A3 != 4'd15);
   assign alu_ok   = ALU_WE && (ALU_A3 != 4'd15);
   assign fifo_ne  = (count_q != '0);

   // The FIFO head has priority over a fresh result; bypass only when nothing is buffered.
   assign pop  = !alu_ok && fifo_ne;
   assign push = mc_ok && (alu_ok || fifo_ne);

   always_comb begin
      we3_d     = 1'b0;
      a3_d      = a3_q;
      wd3_d     = wd3_q;
      pending_d = pending_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      err_d     = (ALU_WE && (ALU_A3 == 4'd15)) || (mc_acc && (MC_A3 == 4'd15));

      if (alu_ok) begin
         we3_d = 1'b1;
         a3_d  = ALU_A3;
         wd3_d = ALU_WD;
      end else if (fifo_ne) begin
         we3_d = 1'b1;
         a3_d  = mem_a3_q[rd_ptr_q];
         wd3_d = mem_wd_q[rd_ptr_q];
         pending_d[mem_a3_q[rd_ptr_q]] = 1'b0;
      end else if (mc_ok) begin
         we3_d = 1'b1;
         a3_d  = MC_A3;
         wd3_d = MC_WD;
         pending_d[MC_A3] = 1'b0;
      end

      // Applied after the clear so an issue to the same register wins.
      if (ISSUE_VALID && (ISSUE_REG != 4'd15))
         pending_d[ISSUE_REG] = 1'b1;

      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push)
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         we3_q     <= 1'b0;
         a3_q      <= 4'd0;
         wd3_q     <= 32'd0;
         err_q     <= 1'b0;
         pending_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         we3_q     <= we3_d;
         a3_q      <= a3_d;
         wd3_q     <= wd3_d;
         err_q     <= err_d;
         pending_q <= pending_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_a3_q[wr_ptr_q] <= MC_A3;
         mem_wd_q[wr_ptr_q] <= MC_WD;
      end
   end

   assign pend_ext   = {1'b0, pending_q};
   assign PEND1      = (Q_A1 != 4'd15) && pend_ext[Q_A1];
   assign PEND2      = (Q_A2 != 4'd15) && pend_ext[Q_A2];
   assign WE3        = we3_q;
   assign A3         = a3_q;
   assign WD3        = wd3_q;
   assign FIFO_COUNT = count_q;
   assign ERR_R15    = err_q;

endmodule
